// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared constants and types for the data-memory SRAM controller
//
// Purpose : parameter defaults, SRAM bus widths and the controller state enum.
// Ports   : none (package).
package arm_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT     = 32'd1024;
    localparam int unsigned ACCESS_CYCLES_DEFAULT = 2;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store port onto a 16-bit asynchronous SRAM
//
// Purpose : splits each 32-bit MEM-stage access into a low half and a high half,
//           each held on the SRAM for ACCESS_CYCLES clocks, then signals ready.
// Ports   : clk, rst_n        clock, asynchronous active-low reset
//           rd_en, wr_en      load / store request (both set -> store)
//           address           byte address, rebased by BASE_ADDR
//           write_data        store word
//           read_data         assembled load word (holds between loads)
//           ready             access finished / no access pending
//           SRAM_DQ           bidirectional SRAM data bus
//           SRAM_ADDR         SRAM half-word address
//           SRAM_WE_N         SRAM write strobe, active-low
module sram_controller
    import arm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    sram_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [16:0]        off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        off;
    logic               req;
    logic               cnt_last;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_out;

    assign off      = address - BASE_ADDR;
    assign req      = rd_en | wr_en;
    assign cnt_last = (cnt_q == LAST_CNT);

    // Only off[18:2] selects a word; the byte offset and upper bits are dropped.
    logic unused_off_bits;
    assign unused_off_bits = ^{off[31:19], off[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state. The counter is cleared whenever a state is (re)entered so each
    // half is exactly ACCESS_CYCLES long. DONE never looks at the enables, so a
    // request still held by a frozen pipeline is not serviced a second time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        op_wr_d = op_wr_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = ST_LOW;
                    op_wr_d = wr_en;
                    off_d   = off[18:2];
                    wdata_d = write_data;
                end
            end
            ST_LOW: begin
                if (cnt_last) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
                end
            end
            ST_HIGH: begin
                if (cnt_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode from registered state only, so reset forces the bus idle at once.
    always_comb begin
        ready     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        unique case (state_q)
            ST_IDLE: ready = ~req;
            ST_LOW: begin
                SRAM_ADDR = {off_q, 1'b0};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = wdata_q[15:0];
            end
            ST_HIGH: begin
                SRAM_ADDR = {off_q, 1'b1};
                SRAM_WE_N = ~op_wr_q;
                dq_oe     = op_wr_q;
                dq_out    = wdata_q[31:16];
            end
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller
module tb_sram_controller;

    typedef struct {
        int          span;
        logic [31:0] rdata;
        logic [17:0] alo;
        logic [17:0] ahi;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_we_n;
    logic [17:0] sram_addr;
    tri   [15:0] sram_dq;

    logic        rd_en2, wr_en2;
    logic [31:0] address2, write_data2, read_data2;
    logic        ready2, sram_we_n2;
    logic [17:0] sram_addr2;
    tri   [15:0] sram_dq2;

    logic [15:0] mem [0:255];
    logic        mem_clr;

    exp_t exp1[$];
    exp_t exp2[$];
    int   n_vec, n_bad;
    int   n_done1, n_done2;

    sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en2), .wr_en(wr_en2),
        .address(address2), .write_data(write_data2), .read_data(read_data2),
        .ready(ready2), .SRAM_DQ(sram_dq2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(sram_we_n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives the bus whenever the controller is not writing.
    assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (!sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_dq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    task automatic drive(input int which, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 1) begin
            wr_en = wr; rd_en = rd; address = a; write_data = d;
        end else begin
            wr_en2 = wr; rd_en2 = rd; address2 = a; write_data2 = d;
        end
    endtask

    // mode 0: plain access; 1: enables held one cycle past DONE; 2: inputs changed mid-access
    task automatic access(input int which, input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] d, input int mode);
        int k;
        @(posedge clk); #1;
        drive(which, wr, rd, a, d);
        if (mode == 2) begin
            @(posedge clk); #1;
            drive(which, wr, rd, a + 32'h40, ~d);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!((which == 1) ? ready : ready2) && k < 40);
        if (k >= 40) fail("ready_timeout");
        @(posedge clk); #1;
        if (mode == 1) begin
            @(posedge clk); #1;
        end
        drive(which, 1'b0, 1'b0, a, d);
    endtask

    task automatic push1(input int span, input logic [31:0] rd, input logic [17:0] lo, input logic [17:0] hi);
        exp_t e;
        e.span = span; e.rdata = rd; e.alo = lo; e.ahi = hi;
        exp1.push_back(e);
    endtask

    task automatic push2(input int span, input logic [31:0] rd, input logic [17:0] lo, input logic [17:0] hi);
        exp_t e;
        e.span = span; e.rdata = rd; e.alo = lo; e.ahi = hi;
        exp2.push_back(e);
    endtask

    // Monitors: measure each ready-low span, sample the SRAM address in the
    // first LOW cycle and the last HIGH cycle, compare on the ready cycle.
    initial begin
        int          span1;
        logic [17:0] alo1, ahi1;
        exp_t        e;
        span1 = 0; alo1 = '0; ahi1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                span1 = 0;
            end else if (!ready) begin
                if (span1 == 1) alo1 = sram_addr;
                ahi1 = sram_addr;
                span1++;
            end else if (span1 != 0) begin
                if (exp1.size() == 0) begin
                    fail("dut1_unexpected_access");
                end else begin
                    e = exp1.pop_front();
                    chk("dut1_ready_low_span", 32'(span1), 32'(e.span));
                    chk("dut1_read_data", read_data, e.rdata);
                    chk("dut1_addr_low", 32'(alo1), 32'(e.alo));
                    chk("dut1_addr_high", 32'(ahi1), 32'(e.ahi));
                end
                n_done1++;
                span1 = 0;
            end
        end
    end

    initial begin
        int          span2;
        logic [17:0] alo2, ahi2;
        exp_t        e;
        span2 = 0; alo2 = '0; ahi2 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                span2 = 0;
            end else if (!ready2) begin
                if (span2 == 1) alo2 = sram_addr2;
                ahi2 = sram_addr2;
                span2++;
            end else if (span2 != 0) begin
                if (exp2.size() == 0) begin
                    fail("dut2_unexpected_access");
                end else begin
                    e = exp2.pop_front();
                    chk("dut2_ready_low_span", 32'(span2), 32'(e.span));
                    chk("dut2_read_data", read_data2, e.rdata);
                    chk("dut2_addr_low", 32'(alo2), 32'(e.alo));
                    chk("dut2_addr_high", 32'(ahi2), 32'(e.ahi));
                end
                n_done2++;
                span2 = 0;
            end
        end
    end

    initial begin
        int k;
        n_vec = 0; n_bad = 0; n_done1 = 0; n_done2 = 0;
        mem_clr = 1'b1;
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_sram_addr", 32'(sram_addr), 32'd0);
        chk("reset_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        mem_clr = 1'b0;
        rst_n = 1'b1;

        // Reset asserted in the first LOW cycle of a write aborts it immediately.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'd1036, 32'h12345678);
        @(negedge clk);
        chk("req_idle_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_low_we_n", 32'(sram_we_n), 32'd0);
        chk("abort_low_addr", 32'(sram_addr), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_sram_addr", 32'(sram_addr), 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(ready), 32'd1);
        chk("post_reset_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_no_write", 32'(mem[6]), 32'h0000);

        // Store then load at the base address.
        push1(5, 32'h0000_0000, 18'd0, 18'd1);
        access(1, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0);
        chk("store_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("store_mem1", 32'(mem[1]), 32'h0000DEAD);
        push1(5, 32'hDEADBEEF, 18'd0, 18'd1);
        access(1, 1'b0, 1'b1, 32'd1024, 32'd0, 0);

        // Word 3 -> half-words 6/7.
        push1(5, 32'hDEADBEEF, 18'd6, 18'd7);
        access(1, 1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 0);
        push1(5, 32'hCAFEF00D, 18'd6, 18'd7);
        access(1, 1'b0, 1'b1, 32'd1036, 32'd0, 0);

        // Both enables -> write; read_data keeps the last load.
        push1(5, 32'hCAFEF00D, 18'd8, 18'd9);
        access(1, 1'b1, 1'b1, 32'd1040, 32'h0BADC0DE, 0);
        chk("both_mem8", 32'(mem[8]), 32'h0000C0DE);
        chk("both_mem9", 32'(mem[9]), 32'h00000BAD);

        // Load held through DONE plus one cycle -> exactly one more access.
        push1(5, 32'hDEADBEEF, 18'd0, 18'd1);
        push1(5, 32'hDEADBEEF, 18'd0, 18'd1);
        access(1, 1'b0, 1'b1, 32'd1024, 32'd0, 1);

        // Single-cycle halves; inputs disturbed mid-access.
        push2(3, 32'h0000_0000, 18'd6, 18'd7);
        access(2, 1'b1, 1'b0, 32'd1036, 32'h55AA33CC, 2);
        push2(3, 32'h0000_0000, 18'd0, 18'd1);
        access(2, 1'b1, 1'b0, 32'd1024, 32'h01020304, 0);

        k = 0;
        while ((exp1.size() != 0 || exp2.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
        chk("dut1_pending", 32'(exp1.size()), 32'd0);
        chk("dut2_pending", 32'(exp2.size()), 32'd0);
        chk("dut1_access_count", 32'(n_done1), 32'd7);
        chk("dut2_access_count", 32'(n_done2), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- BASE_ADDR, 1024: byte address of data memory word 0.
- ACCESS_CYCLES, 2: cycles each 16-bit SRAM half access is held; legal range 1..15.

REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd_en  input  1  MEM-stage load request (LDR).
- wr_en  input  1  MEM-stage store request (STR).
- address  input  32  byte address from ALU result.
- write_data  input  32  store data (Rd value).
- read_data  output  32  assembled load word.
- ready  output  1  access complete; pipeline freeze = (rd_en|wr_en) & ~ready.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  SRAM write strobe, active-low.

Function
REQ-003 Address map SHALL be off = address - BASE_ADDR and SRAM_ADDR = {off[18:2], h}, with h=0 for bits [15:0] and h=1 for bits [31:16]; off[1:0] ignored.
REQ-004 FSM states SHALL be IDLE, LOW, HIGH and DONE.
REQ-005 IDLE SHALL go to LOW when rd_en|wr_en, else stay in IDLE; on that transition it SHALL latch the op (write if wr_en, else read), off and write_data.
REQ-006 LOW and HIGH SHALL each last exactly ACCESS_CYCLES cycles, timed by a 4-bit wait counter cleared on every state entry.
- LOW SHALL go to HIGH when the counter reaches ACCESS_CYCLES-1.
- HIGH SHALL go to DONE when the counter reaches ACCESS_CYCLES-1.
REQ-007 DONE SHALL last one cycle, ignore rd_en/wr_en, and return to IDLE unconditionally, so a frozen request is never serviced twice.
REQ-008 ready SHALL be 1 in DONE, 1 in IDLE when rd_en=wr_en=0, and 0 otherwise.
- Ready-low span per access SHALL be 2*ACCESS_CYCLES+1 cycles, i.e. 5 cycles at the default.
REQ-009 For a read, in the last cycle of LOW SRAM_DQ SHALL be captured into read_data[15:0], and in the last cycle of HIGH into read_data[31:16].
- read_data SHALL otherwise hold its value until the next read overwrites it.
REQ-010 For a write, SRAM_WE_N SHALL be 0 in every LOW and HIGH cycle and 1 in all other states.
- SRAM_DQ SHALL drive latched data [15:0] in LOW and [31:16] in HIGH.
REQ-011 SRAM_DQ SHALL be high-Z in every state except LOW/HIGH of a write.
- SRAM_ADDR SHALL be 0 in IDLE and DONE.
REQ-012 Simultaneous rd_en and wr_en SHALL be serviced as a write.
REQ-013 Changes to address, write_data, rd_en or wr_en after acceptance SHALL NOT affect the access in progress.

Reset
REQ-014 While rst_n=0, and immediately on its assertion, state SHALL be IDLE, counter 0, read_data 0, latched op/off/data 0, SRAM_WE_N 1, SRAM_DQ high-Z and SRAM_ADDR 0.
REQ-015 Reset asserted mid-access SHALL abort the access; no further SRAM_WE_N pulse SHALL occur, and the next access SHALL start cleanly from IDLE.

Structure
REQ-016 The state enum, BASE_ADDR default, SRAM address/data widths and ACCESS_CYCLES default SHALL live in shared package arm_pkg.
REQ-017 No sub-module is needed; the counter, FSM and tristate driver SHALL live in sram_controller.

Verification
REQ-018 Reset: rst_n=0 mid-LOW of a write -> SRAM_WE_N=1 and DQ high-Z in the same cycle; after release, state IDLE and ready=1 with no request.
REQ-019 Store then load: wr_en, address=1024, data=0xDEADBEEF -> SRAM[0]=0xBEEF and SRAM[1]=0xDEAD, ready low 5 cycles; then rd_en to the same address -> read_data=0xDEADBEEF on the ready cycle.
REQ-020 Addressing: address=1036 -> SRAM_ADDR 6 in LOW and 7 in HIGH.
REQ-021 Held request: rd_en held high through DONE and one more cycle -> exactly one new access starts, in the cycle after DONE.
REQ-022 Both enables: rd_en=wr_en=1 -> write performed and read_data unchanged.
REQ-023 Stability and timing: with ACCESS_CYCLES=1, ready low 3 cycles; changing address mid-access does not alter SRAM_ADDR.
